uart_host_link: RTL

UART_HOST_LINK -- requirements
Module: uart_host_link

---
 rtl/uart_host_link.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/uart_host_link.sv
// Host end of a UART link: sends one 8N1 frame, receives one 8N1 reply and
// compares the reply against the expected byte.
module uart_host_link #(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned TIMEOUT_CLKS = 1000000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic [7:0] expect_byte,
  output logic       utx,
  input  logic       urx,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] rx_byte,
  output logic       frame_err,
  output logic       timeout_err
);

  localparam int unsigned BIT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned TO_W      = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam int unsigned HALF_CLKS = (CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 : 1;

  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] HALF_LAST = BIT_W'(HALF_CLKS - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CLKS - 1);

  typedef enum logic [3:0] {
    IDLE, TX_START, TX_DATA, TX_STOP, WAIT_RX, RX_START, RX_DATA, RX_STOP, DONE
  } state_t;

  state_t           state;
  logic [BIT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [TO_W-1:0]  to_cnt;
  logic [7:0]       tx_shift;
  logic [7:0]       exp_q;
  logic             rx_meta;
  logic             rx_sync;
  logic             bit_done;
  logic [TO_W-1:0]  to_next;

  assign bit_done = (bit_cnt == BIT_LAST);
  // Timeout count saturates so a false start near the end cannot wrap it.
  assign to_next  = (to_cnt == TO_LAST) ? to_cnt : to_cnt + TO_W'(1);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      bit_idx     <= '0;
      to_cnt      <= '0;
      tx_shift    <= '0;
      exp_q       <= '0;
      rx_meta     <= 1'b1;
      rx_sync     <= 1'b1;
      utx         <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      rx_byte     <= '0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      rx_meta <= urx;
      rx_sync <= rx_meta;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            tx_shift    <= tx_byte;
            exp_q       <= expect_byte;
            frame_err   <= 1'b0;
            timeout_err <= 1'b0;
            pass        <= 1'b0;
            busy        <= 1'b1;
            utx         <= 1'b0;
            bit_cnt     <= '0;
            state       <= TX_START;
          end
        end
        TX_START: begin
          if (bit_done) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            utx     <= tx_shift[0];
            state   <= TX_DATA;
          end else begin
            bit_cnt <= bit_cnt + BIT_W'(1);
          end
        end
        TX_DATA: begin
          if (bit_done) begin
            bit_cnt <= '0;
            if (bit_idx == 3'd7) begin
              utx   <= 1'b1;
              state <= TX_STOP;
            end else begin
              bit_idx  <= bit_idx + 3'd1;
              tx_shift <= {1'b0, tx_shift[7:1]};
              utx      <= tx_shift[1];
            end
          end else begin
            bit_cnt <= bit_cnt + BIT_W'(1);
          end
        end
        TX_STOP: begin
          if (bit_done) begin
            bit_cnt <= '0;
            to_cnt  <= '0;
            state   <= WAIT_RX;
          end else begin
            bit_cnt <= bit_cnt + BIT_W'(1);
          end
        end
        WAIT_RX: begin
          if (!rx_sync) begin
            bit_cnt <= '0;
            to_cnt  <= to_next;
            state   <= RX_START;
          end else if (to_cnt == TO_LAST) begin
            timeout_err <= 1'b1;
            pass        <= 1'b0;
            done        <= 1'b1;
            state       <= DONE;
          end else begin
            to_cnt <= to_next;
          end
        end
        RX_START: begin
          // Timeout window keeps running so a rejected glitch does not extend it.
          to_cnt <= to_next;
          if (bit_cnt == HALF_LAST) begin
            bit_cnt <= '0;
            if (rx_sync) begin
              state <= WAIT_RX;
            end else begin
              bit_idx <= '0;
              state   <= RX_DATA;
            end
          end else begin
            bit_cnt <= bit_cnt + BIT_W'(1);
          end
        end
        RX_DATA: begin
          if (bit_done) begin
            bit_cnt <= '0;
            rx_byte <= {rx_sync, rx_byte[7:1]};
            if (bit_idx == 3'd7) begin
              state <= RX_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            bit_cnt <= bit_cnt + BIT_W'(1);
          end
        end
        RX_STOP: begin
          if (bit_done) begin
            bit_cnt   <= '0;
            frame_err <= ~rx_sync;
            pass      <= rx_sync & (rx_byte == exp_q);
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            bit_cnt <= bit_cnt + BIT_W'(1);
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
